id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register and operand-select stage that directly feeds the ALU (data1, data2, shamt, alu_ctrl).
//   - Latches decoded operands and control each cycle.
//   - Resolves EX/MEM and MEM/WB forwarding.
//   - Detects load-use hazards and inserts bubbles.
//   - Applies hold (downstream stall) and flush (branch redirect).
// PARAMETERS
//   DATA_W   32  operand / result width
//   REG_AW   5   register-file address width
//   CTRL_W   4   alu_ctrl width (ADD=1 SUB=2 AND=3 OR=4 XOR=5 LUI=6 SLT=7 SLL=8 SRL=9)
//   SHAMT_W  6   shift-amount width presented to the ALU
// PORTS
//   clk            in   1        single clock; all state updates on rising edge
//   rst            in   1        synchronous, active-high reset
//   id_valid       in   1        decode slot holds a real instruction
//   id_rs_data     in   DATA_W   register-file read of rs
//   id_rt_data     in   DATA_W   register-file read of rt
//   id_imm         in   DATA_W   sign/zero-extended immediate
//   id_shamt       in   SHAMT_W  shift amount
//   id_alu_ctrl    in   CTRL_W   ALU opcode
//   id_alu_src     in   1        1: data2 = imm; 0: data2 = forwarded rt
//   id_rs, id_rt   in   REG_AW   source register numbers
//   id_rd          in   REG_AW   destination register number
//   id_reg_write   in   1        instruction writes rd
//   id_mem_read    in   1        load
//   id_mem_write   in   1        store
//   hold           in   1        downstream stall: freeze this stage
//   flush          in   1        kill the instruction in ID and the one in this stage
//   exm_reg_write  in   1        EX/MEM stage writes exm_rd
//   exm_rd         in   REG_AW
//   exm_res        in   DATA_W   EX/MEM ALU result
//   mwb_reg_write  in   1        MEM/WB stage writes mwb_rd
//   mwb_rd         in   REG_AW
//   mwb_res        in   DATA_W   MEM/WB writeback value
//   id_stall       out  1        load-use hazard: IF/ID must hold (combinational)
//   data1          out  DATA_W   ALU operand A (forwarded rs)
//   data2          out  DATA_W   ALU operand B (imm or forwarded rt)
//   shamt          out  SHAMT_W
//   alu_ctrl       out  CTRL_W
//   ex_store_data  out  DATA_W   forwarded rt for stores
//   ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write   out   registered control to EX/MEM
// BEHAVIOUR
//   - Reset (rst=1 at edge): every register clears to 0; ex_valid=0, alu_ctrl=0 (ALU outputs 0); id_stall=0.
//   - Latency: 1 cycle from ID inputs to registered fields; forwarding is combinational on the registered fields.
//   - Register update priority per edge: rst > flush > hold > bubble > capture.
//     - flush: load bubble (valid=0, reg_write=mem_read=mem_write=0, alu_ctrl=0).
//     - hold: keep all registers unchanged.
//     - bubble: id_stall=1 -> load bubble.
//     - capture: latch ID; control bits are ANDed with id_valid.
//   - id_stall = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs | ex_rd==id_rt). Forced 0 while flush=1.
//   - Forwarding, per source (rs->data1, rt->ex_store_data / data2 base):
//     - if exm_reg_write & exm_rd!=0 & exm_rd==src: use exm_res
//     - else if mwb_reg_write & mwb_rd!=0 & mwb_rd==src: use mwb_res
//     - else use the latched register value.
//     - EX/MEM beats MEM/WB when both match. Register 0 is never forwarded.
//   - data2 = alu_src ? imm : forwarded rt. ex_store_data is always forwarded rt.
//   - Bubble outputs: ex_valid=0 and all write enables 0, so no architectural effect.
//   - A simultaneous hold and load-use hazard keeps the stage frozen; id_stall stays asserted.
// STRUCTURE
//   - Shared package: ALU opcode localparams (ADD..SRL) and a BUBBLE control constant.
//   - One sub-module, fwd_mux: 2-level priority forward select, instantiated twice (rs, rt).
// TESTING
//   1. Reset: rst=1 for 2 cycles with random ID inputs -> all outputs 0, id_stall=0.
//   2. EX/MEM forward:
//      - latch ADD rs=3, rt=4 (rf: 10, 20); exm_rd=3, exm_res=0x55, exm_reg_write=1 -> data1=0x55, data2=20.
//      - rd=0 variant -> data1=10.
//   3. Forward priority: exm_rd=mwb_rd=5, exm_res=1, mwb_res=2, ex rs=5 -> data1=1.
//      - Drop exm_reg_write -> data1=2.
//   4. Load-use:
//      - ex holds lw rd=7; ID instruction uses rt=7 -> id_stall=1.
//      - Next cycle: ex_valid=0; the ID instruction captured one cycle later.
//   5. Flush vs hold: hold=1 and flush=1 in the same cycle -> bubble loaded (flush wins).
//      - hold=1 alone for 3 cycles -> outputs unchanged.
//   6. Immediate path: alu_src=1, imm=0xFFFFFFF0, alu_ctrl=LUI -> data2=0xFFFFFFF0; ex_store_data = forwarded rt.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU opcodes, the registered
// control bundle, the bubble constant and the forward-select encoding.
package id_ex_stage_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 4'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_LUI = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'd9;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
  } ex_ctrl_t;

  // No valid instruction, no write enables, ALU opcode 0 (ALU outputs 0).
  localparam ex_ctrl_t BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of every ID/EX stage signal except clk/rst.
//   master: upstream/downstream environment (drives decode, hold/flush and
//           forwarding sources; observes ALU operands and EX control)
//   slave : the id_ex_stage itself
interface id_ex_stage_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned SHAMT_W = 6
);
  // decode slot
  logic               id_valid;
  logic [DATA_W-1:0]  id_rs_data;
  logic [DATA_W-1:0]  id_rt_data;
  logic [DATA_W-1:0]  id_imm;
  logic [SHAMT_W-1:0] id_shamt;
  logic [CTRL_W-1:0]  id_alu_ctrl;
  logic               id_alu_src;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic               id_reg_write;
  logic               id_mem_read;
  logic               id_mem_write;
  // pipeline control
  logic               hold;
  logic               flush;
  // forwarding sources
  logic               exm_reg_write;
  logic [REG_AW-1:0]  exm_rd;
  logic [DATA_W-1:0]  exm_res;
  logic               mwb_reg_write;
  logic [REG_AW-1:0]  mwb_rd;
  logic [DATA_W-1:0]  mwb_res;
  // stage outputs
  logic               id_stall;
  logic [DATA_W-1:0]  data1;
  logic [DATA_W-1:0]  data2;
  logic [SHAMT_W-1:0] shamt;
  logic [CTRL_W-1:0]  alu_ctrl;
  logic [DATA_W-1:0]  ex_store_data;
  logic               ex_valid;
  logic [REG_AW-1:0]  ex_rd;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic               ex_mem_write;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_ctrl,
           id_alu_src, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
           id_mem_write, hold, flush, exm_reg_write, exm_rd, exm_res,
           mwb_reg_write, mwb_rd, mwb_res,
    input  id_stall, data1, data2, shamt, alu_ctrl, ex_store_data, ex_valid,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_ctrl,
           id_alu_src, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
           id_mem_write, hold, flush, exm_reg_write, exm_rd, exm_res,
           mwb_reg_write, mwb_rd, mwb_res,
    output id_stall, data1, data2, shamt, alu_ctrl, ex_store_data, ex_valid,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: two-level priority operand forward select.
//   src          register number of the operand
//   reg_val      latched register-file value
//   exm_*/mwb_*  EX/MEM and MEM/WB writeback candidates
//   fwd_val      selected operand (EX/MEM beats MEM/WB; r0 never forwarded)
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_res,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_res,
  output logic [DATA_W-1:0] fwd_val
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == src)) begin
      sel = FWD_EXM;
    end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == src)) begin
      sel = FWD_MWB;
    end
  end

  always_comb begin
    fwd_val = reg_val;
    unique case (sel)
      FWD_EXM: fwd_val = exm_res;
      FWD_MWB: fwd_val = mwb_res;
      default: fwd_val = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register and ALU operand select.
//   clk, rst  single clock, synchronous active-high reset
//   bus       id_ex_stage_if.slave: decode inputs, hold/flush, forwarding
//             sources in; ALU operands, EX control and id_stall out
// Register update priority: rst > flush > hold > load-use bubble > capture.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned SHAMT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  id_ex_stage_if.slave   bus
);

  ex_ctrl_t           ctrl_q,    ctrl_d;
  logic [DATA_W-1:0]  rs_data_q, rs_data_d;
  logic [DATA_W-1:0]  rt_data_q, rt_data_d;
  logic [DATA_W-1:0]  imm_q,     imm_d;
  logic [SHAMT_W-1:0] shamt_q,   shamt_d;
  logic               alu_src_q, alu_src_d;
  logic [REG_AW-1:0]  rs_q,      rs_d;
  logic [REG_AW-1:0]  rt_q,      rt_d;
  logic [REG_AW-1:0]  rd_q,      rd_d;

  logic               load_use;
  logic [DATA_W-1:0]  rs_fwd;
  logic [DATA_W-1:0]  rt_fwd;

  always_comb begin
    load_use = ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) && bus.id_valid &&
               ((rd_q == bus.id_rs) || (rd_q == bus.id_rt));
  end

  // A flushed ID instruction must not hold IF/ID.
  assign bus.id_stall = load_use && !bus.flush;

  always_comb begin
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    shamt_d   = shamt_q;
    alu_src_d = alu_src_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    if (bus.flush || (!bus.hold && load_use)) begin
      // Bubble also zeroes the datapath fields so a bubble is
      // indistinguishable from the reset state on every output.
      ctrl_d    = BUBBLE;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      shamt_d   = '0;
      alu_src_d = 1'b0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
    end else if (!bus.hold) begin
      ctrl_d.valid     = bus.id_valid;
      ctrl_d.reg_write = bus.id_valid & bus.id_reg_write;
      ctrl_d.mem_read  = bus.id_valid & bus.id_mem_read;
      ctrl_d.mem_write = bus.id_valid & bus.id_mem_write;
      ctrl_d.alu_ctrl  = bus.id_valid ? ALU_CTRL_W'(bus.id_alu_ctrl) : '0;
      rs_data_d = bus.id_rs_data;
      rt_data_d = bus.id_rt_data;
      imm_d     = bus.id_imm;
      shamt_d   = bus.id_shamt;
      alu_src_d = bus.id_alu_src;
      rs_d      = bus.id_rs;
      rt_d      = bus.id_rt;
      rd_d      = bus.id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= BUBBLE;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
      alu_src_q <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      shamt_q   <= shamt_d;
      alu_src_q <= alu_src_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src           (rs_q),
    .reg_val       (rs_data_q),
    .exm_reg_write (bus.exm_reg_write),
    .exm_rd        (bus.exm_rd),
    .exm_res       (bus.exm_res),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_rd        (bus.mwb_rd),
    .mwb_res       (bus.mwb_res),
    .fwd_val       (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src           (rt_q),
    .reg_val       (rt_data_q),
    .exm_reg_write (bus.exm_reg_write),
    .exm_rd        (bus.exm_rd),
    .exm_res       (bus.exm_res),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_rd        (bus.mwb_rd),
    .mwb_res       (bus.mwb_res),
    .fwd_val       (rt_fwd)
  );

  assign bus.data1         = rs_fwd;
  assign bus.data2         = alu_src_q ? imm_q : rt_fwd;
  assign bus.ex_store_data = rt_fwd;
  assign bus.shamt         = shamt_q;
  assign bus.alu_ctrl      = CTRL_W'(ctrl_q.alu_ctrl);
  assign bus.ex_valid      = ctrl_q.valid;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with hand-computed expected values.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(4), .SHAMT_W(6)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(4), .SHAMT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [5:0] sh, input logic [3:0] ctrl,
                        input logic src, input logic rw, input logic mr, input logic mw);
    bus.id_valid     = v;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_rs_data   = rsd;
    bus.id_rt_data   = rtd;
    bus.id_imm       = imm;
    bus.id_shamt     = sh;
    bus.id_alu_ctrl  = ctrl;
    bus.id_alu_src   = src;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
  endtask

  task automatic fwd_off();
    bus.exm_reg_write = 1'b0;
    bus.exm_rd        = '0;
    bus.exm_res       = '0;
    bus.mwb_reg_write = 1'b0;
    bus.mwb_rd        = '0;
    bus.mwb_res       = '0;
  endtask

  task automatic rand_id();
    set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
           $urandom, 6'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    fwd_off();

    // Reset with random decode inputs
    rand_id();
    tick();
    rand_id();
    tick();
    check("rst_data1", bus.data1, 32'h0);
    check("rst_data2", bus.data2, 32'h0);
    check("rst_store", bus.ex_store_data, 32'h0);
    check("rst_shamt", 32'(bus.shamt), 32'h0);
    check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'h0);
    check("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
    check("rst_ex_rd", 32'(bus.ex_rd), 32'h0);
    check("rst_ctrl_wr", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}), 32'h0);
    check("rst_id_stall", 32'(bus.id_stall), 32'h0);
    rst = 1'b0;

    // EX/MEM forward: ADD rs=3 rt=4 (10, 20)
    set_id(1, 3, 4, 6, 10, 20, 0, 0, ALU_ADD, 0, 1, 0, 0);
    tick();
    bus.exm_reg_write = 1'b1;
    bus.exm_rd        = 5'd3;
    bus.exm_res       = 32'h55;
    #1;
    check("exm_fwd_data1", bus.data1, 32'h55);
    check("exm_fwd_data2", bus.data2, 32'd20);
    check("add_ex_valid", 32'(bus.ex_valid), 32'h1);
    check("add_ex_rd", 32'(bus.ex_rd), 32'd6);
    check("add_alu_ctrl", 32'(bus.alu_ctrl), 32'(ALU_ADD));
    check("add_reg_write", 32'(bus.ex_reg_write), 32'h1);

    // Register 0 is never forwarded
    fwd_off();
    set_id(1, 0, 4, 6, 10, 20, 0, 0, ALU_ADD, 0, 1, 0, 0);
    tick();
    bus.exm_reg_write = 1'b1;
    bus.exm_rd        = 5'd0;
    bus.exm_res       = 32'h55;
    #1;
    check("r0_no_fwd", bus.data1, 32'd10);

    // Forward priority
    fwd_off();
    set_id(1, 5, 0, 6, 32'h99, 0, 0, 0, ALU_ADD, 0, 1, 0, 0);
    tick();
    bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd5; bus.exm_res = 32'd1;
    bus.mwb_reg_write = 1'b1; bus.mwb_rd = 5'd5; bus.mwb_res = 32'd2;
    #1;
    check("prio_exm", bus.data1, 32'd1);
    bus.exm_reg_write = 1'b0;
    #1;
    check("prio_mwb", bus.data1, 32'd2);
    bus.mwb_reg_write = 1'b0;
    #1;
    check("prio_rf", bus.data1, 32'h99);
    fwd_off();

    // Load-use: lw rd=7, then ADD using rt=7
    set_id(1, 1, 0, 7, 32'h1000, 0, 4, 0, ALU_ADD, 1, 1, 1, 0);
    tick();
    set_id(1, 2, 7, 8, 100, 200, 0, 0, ALU_ADD, 0, 1, 0, 0);
    #1;
    check("lu_stall", 32'(bus.id_stall), 32'h1);
    check("lu_ex_mem_read", 32'(bus.ex_mem_read), 32'h1);
    tick();
    check("lu_bubble_valid", 32'(bus.ex_valid), 32'h0);
    check("lu_bubble_rw", 32'(bus.ex_reg_write), 32'h0);
    check("lu_bubble_alu", 32'(bus.alu_ctrl), 32'h0);
    check("lu_stall_clear", 32'(bus.id_stall), 32'h0);
    tick();
    check("lu_capture_valid", 32'(bus.ex_valid), 32'h1);
    check("lu_capture_rd", 32'(bus.ex_rd), 32'd8);
    check("lu_capture_data1", bus.data1, 32'd100);
    check("lu_capture_data2", bus.data2, 32'd200);

    // Flush wins over hold
    bus.hold  = 1'b1;
    bus.flush = 1'b1;
    tick();
    check("flush_valid", 32'(bus.ex_valid), 32'h0);
    check("flush_rd", 32'(bus.ex_rd), 32'h0);
    check("flush_rw", 32'(bus.ex_reg_write), 32'h0);
    bus.hold  = 1'b0;
    bus.flush = 1'b0;

    // Hold alone for 3 cycles
    set_id(1, 9, 10, 11, 32'h1234, 32'h5678, 0, 3, ALU_XOR, 0, 1, 0, 0);
    tick();
    bus.hold = 1'b1;
    set_id(1, 12, 13, 12, 32'hDEAD, 32'hBEEF, 0, 7, ALU_ADD, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_rd", 32'(bus.ex_rd), 32'd11);
      check("hold_data1", bus.data1, 32'h1234);
      check("hold_data2", bus.data2, 32'h5678);
      check("hold_alu", 32'(bus.alu_ctrl), 32'(ALU_XOR));
      check("hold_shamt", 32'(bus.shamt), 32'd3);
    end
    bus.hold = 1'b0;

    // Hold together with load-use hazard
    set_id(1, 1, 0, 7, 0, 0, 4, 0, ALU_ADD, 1, 1, 1, 0);
    tick();
    bus.hold = 1'b1;
    set_id(1, 7, 2, 9, 0, 0, 0, 0, ALU_ADD, 0, 1, 0, 0);
    #1;
    check("hold_lu_stall", 32'(bus.id_stall), 32'h1);
    tick();
    check("hold_lu_rd", 32'(bus.ex_rd), 32'd7);
    check("hold_lu_mr", 32'(bus.ex_mem_read), 32'h1);
    check("hold_lu_stall2", 32'(bus.id_stall), 32'h1);
    bus.flush = 1'b1;
    #1;
    check("flush_masks_stall", 32'(bus.id_stall), 32'h0);
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    tick();
    check("hold_lu_bubble", 32'(bus.ex_valid), 32'h0);

    // Immediate path with rt forwarded to store data
    set_id(1, 0, 4, 13, 0, 20, 32'hFFFF_FFF0, 0, ALU_LUI, 1, 1, 0, 0);
    tick();
    bus.mwb_reg_write = 1'b1; bus.mwb_rd = 5'd4; bus.mwb_res = 32'hABCD;
    #1;
    check("imm_data2", bus.data2, 32'hFFFF_FFF0);
    check("imm_store", bus.ex_store_data, 32'hABCD);
    check("imm_alu", 32'(bus.alu_ctrl), 32'(ALU_LUI));
    fwd_off();

    // Invalid ID slot gates control
    set_id(0, 1, 2, 14, 0, 0, 0, 0, ALU_ADD, 0, 1, 0, 1);
    tick();
    check("inv_valid", 32'(bus.ex_valid), 32'h0);
    check("inv_ctrl", 32'({bus.ex_reg_write, bus.ex_mem_write}), 32'h0);
    set_id(1, 1, 2, 0, 0, 32'h77, 8, 0, ALU_ADD, 1, 0, 0, 1);
    tick();
    check("store_mw", 32'(bus.ex_mem_write), 32'h1);
    check("store_data", bus.ex_store_data, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
